// File: rtl/lock_entry_controller.sv
// Keypad front end: debounces raw codes into one-cycle strobes, cancels stale
// entries after an idle timeout, counts failed attempts and enforces a timed lockout.
module lock_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int IDLE_TIMEOUT    = 1000,
    parameter int MAX_FAILS       = 3,
    parameter int LOCKOUT_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_raw,
    input  logic       core_wrong,
    input  logic       core_unlocked,
    output logic [3:0] key_out,
    output logic       key_valid,
    output logic       lockout,
    output logic [2:0] fail_count,
    output logic [1:0] state_dbg
);
    // key_valid qualifies key_out for exactly one cycle; there is no backpressure,
    // the core must consume every strobe in the cycle it is presented.
    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_RELEASE, S_LOCKOUT} state_t;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] IDLE_MAX  = TW'(IDLE_TIMEOUT);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]    FAIL_MAX  = 3'(MAX_FAILS);

    localparam logic [3:0] KEY_NONE   = 4'b1111;
    localparam logic [3:0] KEY_CANCEL = 4'b1101;
    localparam logic [3:0] KEY_SET    = 4'b1110;

    state_t        state, state_nxt;
    logic [DW-1:0] deb_cnt, deb_cnt_nxt;
    logic [3:0]    key_lat, key_lat_nxt;
    logic [LW-1:0] lock_cnt, lock_cnt_nxt;
    logic [TW-1:0] idle_timer, idle_timer_nxt;
    logic          entry_open, entry_open_nxt;
    logic          wrong_q, unlocked_q;
    logic [3:0]    key_out_nxt;
    logic          key_valid_nxt;
    logic          lockout_nxt;
    logic [2:0]    fail_nxt;

    logic          wrong_rise, unlock_rise, timeout_hit, auto_cancel;
    logic          strobe_due, lock_done, enter_lock, entry_key;
    logic [2:0]    fail_inc;

    // Wrong-code edges are ignored while locked out; the edge register still tracks
    // the level so a wrong level held across lockout cannot retrigger afterwards.
    assign wrong_rise  = core_wrong & ~wrong_q & (state != S_LOCKOUT);
    assign unlock_rise = core_unlocked & ~unlocked_q;
    assign timeout_hit = entry_open && (idle_timer == IDLE_LAST);
    assign auto_cancel = (wrong_rise || timeout_hit) && (state != S_LOCKOUT);
    assign fail_inc    = (fail_count == FAIL_MAX) ? fail_count : fail_count + 3'd1;
    assign enter_lock  = wrong_rise && (fail_inc == FAIL_MAX);
    assign strobe_due  = (state == S_PRESS) && (key_raw == key_lat) && (deb_cnt == DEB_LAST);
    assign lock_done   = (state == S_LOCKOUT) && (lock_cnt == LOCK_LAST);
    assign entry_key   = ((key_lat >= 4'd1) && (key_lat <= 4'd9)) || (key_lat == KEY_SET);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            deb_cnt    <= '0;
            key_lat    <= KEY_NONE;
            lock_cnt   <= '0;
            idle_timer <= '0;
            entry_open <= 1'b0;
            wrong_q    <= 1'b0;
            unlocked_q <= 1'b0;
            key_out    <= KEY_NONE;
            key_valid  <= 1'b0;
            lockout    <= 1'b0;
            fail_count <= '0;
        end else begin
            state      <= state_nxt;
            deb_cnt    <= deb_cnt_nxt;
            key_lat    <= key_lat_nxt;
            lock_cnt   <= lock_cnt_nxt;
            idle_timer <= idle_timer_nxt;
            entry_open <= entry_open_nxt;
            wrong_q    <= core_wrong;
            unlocked_q <= core_unlocked;
            key_out    <= key_out_nxt;
            key_valid  <= key_valid_nxt;
            lockout    <= lockout_nxt;
            fail_count <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        deb_cnt_nxt  = deb_cnt;
        key_lat_nxt  = key_lat;
        lock_cnt_nxt = lock_cnt;
        case (state)
            S_IDLE: begin
                if (key_raw != KEY_NONE) begin
                    key_lat_nxt = key_raw;
                    deb_cnt_nxt = DW'(1);
                    state_nxt   = S_PRESS;
                end
            end
            S_PRESS: begin
                if (key_raw == KEY_NONE) begin
                    deb_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end else if (key_raw != key_lat) begin
                    key_lat_nxt = key_raw;
                    deb_cnt_nxt = DW'(1);
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt_nxt = '0;
                    state_nxt   = S_RELEASE;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end
            end
            S_RELEASE: begin
                if (key_raw != KEY_NONE) begin
                    deb_cnt_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    deb_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    deb_cnt_nxt = deb_cnt + DW'(1);
                end
            end
            S_LOCKOUT: begin
                // Leave through RELEASE so a key held across the boundary is not accepted.
                if (lock_done) begin
                    lock_cnt_nxt = '0;
                    deb_cnt_nxt  = '0;
                    state_nxt    = S_RELEASE;
                end else begin
                    lock_cnt_nxt = lock_cnt + LW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (enter_lock) begin
            state_nxt    = S_LOCKOUT;
            deb_cnt_nxt  = '0;
            lock_cnt_nxt = '0;
        end
    end

    always_comb begin
        key_out_nxt    = KEY_NONE;
        key_valid_nxt  = 1'b0;
        entry_open_nxt = entry_open;
        idle_timer_nxt = '0;
        fail_nxt       = fail_count;
        lockout_nxt    = lockout;
        if (entry_open && (idle_timer != IDLE_MAX))
            idle_timer_nxt = idle_timer + TW'(1);
        // An auto-cancel pre-empts a key strobe due in the same cycle.
        if (auto_cancel) begin
            key_out_nxt    = KEY_CANCEL;
            key_valid_nxt  = 1'b1;
            entry_open_nxt = 1'b0;
            idle_timer_nxt = '0;
        end else if (strobe_due) begin
            key_out_nxt    = key_lat;
            key_valid_nxt  = 1'b1;
            idle_timer_nxt = '0;
            if (key_lat == KEY_CANCEL)
                entry_open_nxt = 1'b0;
            else if (entry_key)
                entry_open_nxt = 1'b1;
        end
        if (unlock_rise) begin
            fail_nxt       = '0;
            entry_open_nxt = 1'b0;
        end
        if (wrong_rise)
            fail_nxt = fail_inc;
        if (enter_lock)
            lockout_nxt = 1'b1;
        if (lock_done) begin
            lockout_nxt = 1'b0;
            fail_nxt    = '0;
        end
    end

endmodule

// File: tb/tb_lock_entry_controller.sv
// Directed bench for lock_entry_controller with D=4, T=20, MAX_FAILS=3, L=50:
// a vector table for debounce behaviour plus hand sequences for timeout and lockout.
module tb_lock_entry_controller;

    localparam logic [3:0] NK = 4'hF;
    localparam logic [3:0] CK = 4'hD;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_raw;
    logic       core_wrong;
    logic       core_unlocked;
    logic [3:0] key_out;
    logic       key_valid;
    logic       lockout;
    logic [2:0] fail_count;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0] key;
        logic       wrong;
        logic       unlk;
        logic [3:0] exp_key;
        logic       exp_lock;
        logic [2:0] exp_fail;
    } vec_t;

    vec_t vecs[$];

    lock_entry_controller #(
        .DEBOUNCE_CYCLES(4),
        .IDLE_TIMEOUT   (20),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (50)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_raw      (key_raw),
        .core_wrong   (core_wrong),
        .core_unlocked(core_unlocked),
        .key_out      (key_out),
        .key_valid    (key_valid),
        .lockout      (lockout),
        .fail_count   (fail_count),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ek, input logic el,
                              input logic [2:0] ef);
        chk({tag, " key_out"},    {4'b0, key_out},    {4'b0, ek});
        chk({tag, " key_valid"},  {7'b0, key_valid},  {7'b0, (ek != NK)});
        chk({tag, " lockout"},    {7'b0, lockout},    {7'b0, el});
        chk({tag, " fail_count"}, {5'b0, fail_count}, {5'b0, ef});
    endtask

    task automatic step(input logic [3:0] k, input logic w, input logic u);
        key_raw       = k;
        core_wrong    = w;
        core_unlocked = u;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] k, input logic [3:0] ek, input int n);
        for (int i = 0; i < n; i++)
            vecs.push_back('{key: k, wrong: 1'b0, unlk: 1'b0, exp_key: ek,
                             exp_lock: 1'b0, exp_fail: 3'd0});
    endtask

    initial begin
        logic [3:0] ek;
        rst = 1'b1;
        key_raw = NK;
        core_wrong = 1'b0;
        core_unlocked = 1'b0;

        // Bounce rejection, then a genuine press 4 samples after onset.
        add(4'h3, NK, 3);
        add(NK,   NK, 1);
        add(4'h3, NK, 3);
        add(4'h3, 4'h3, 1);
        add(4'h3, NK, 6);
        add(NK,   NK, 4);
        // Code change mid-press: only the second code is strobed.
        add(4'h2, NK, 2);
        add(4'h5, NK, 3);
        add(4'h5, 4'h5, 1);
        add(4'h5, NK, 2);
        add(NK,   NK, 4);
        // User cancel closes the entry.
        add(CK,   NK, 3);
        add(CK,   CK, 1);
        add(NK,   NK, 4);

        // Reset state.
        step(NK, 0, 0);
        step(NK, 0, 0);
        expect_out("reset", NK, 1'b0, 3'd0);
        chk("reset state_dbg", {6'b0, state_dbg}, 8'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].key, vecs[i].wrong, vecs[i].unlk);
            expect_out($sformatf("vec%0d", i), vecs[i].exp_key, vecs[i].exp_lock,
                       vecs[i].exp_fail);
        end

        // Idle timeout: cancel exactly 20 cycles after the digit strobe.
        for (int i = 1; i <= 4; i++) step(4'h1, 0, 0);
        expect_out("to1 press", 4'h1, 1'b0, 3'd0);
        for (int i = 1; i <= 20; i++) begin
            step(NK, 0, 0);
            ek = (i == 20) ? CK : NK;
            chk($sformatf("to1 step%0d key_out", i), {4'b0, key_out}, {4'b0, ek});
        end

        // A key accepted 15 cycles in restarts the timeout.
        for (int i = 1; i <= 4; i++) step(4'h1, 0, 0);
        expect_out("to2 press", 4'h1, 1'b0, 3'd0);
        for (int i = 1; i <= 40; i++) begin
            step((i >= 12 && i <= 15) ? 4'h2 : NK, 0, 0);
            ek = (i == 15) ? 4'h2 : (i == 35) ? CK : NK;
            chk($sformatf("to2 step%0d key_out", i), {4'b0, key_out}, {4'b0, ek});
        end

        // Three wrong attempts lead to lockout with the third cancel.
        step(NK, 1, 0); expect_out("fail1", CK, 1'b0, 3'd1);
        step(NK, 0, 0); expect_out("fail1 low", NK, 1'b0, 3'd1);
        step(NK, 1, 0); expect_out("fail2", CK, 1'b0, 3'd2);
        step(NK, 0, 0); expect_out("fail2 low", NK, 1'b0, 3'd2);
        step(NK, 1, 0); expect_out("fail3", CK, 1'b1, 3'd3);
        for (int i = 1; i <= 60; i++) begin
            step(4'h7, (i == 10), 0);
            expect_out($sformatf("lock%0d", i), NK, (i < 50), (i < 50) ? 3'd3 : 3'd0);
        end
        for (int i = 1; i <= 4; i++) begin
            step(NK, 0, 0);
            expect_out($sformatf("lockrel%0d", i), NK, 1'b0, 3'd0);
        end

        // Unlock clears the fail count; one later fail does not lock out.
        step(NK, 1, 0); expect_out("ul fail1", CK, 1'b0, 3'd1);
        step(NK, 0, 0);
        step(NK, 1, 0); expect_out("ul fail2", CK, 1'b0, 3'd2);
        step(NK, 0, 0);
        step(NK, 0, 1); expect_out("ul unlock", NK, 1'b0, 3'd0);
        step(NK, 0, 0);
        step(NK, 1, 0); expect_out("ul fail again", CK, 1'b0, 3'd1);
        step(NK, 0, 0); expect_out("ul low", NK, 1'b0, 3'd1);

        // Cancel wins over a key strobe due on the same edge.
        for (int i = 1; i <= 3; i++) step(4'h6, 0, 0);
        step(4'h6, 1, 0); expect_out("race cancel", CK, 1'b0, 3'd2);
        for (int i = 1; i <= 6; i++) begin
            step((i <= 2) ? 4'h6 : NK, 0, 0);
            expect_out($sformatf("race after%0d", i), NK, 1'b0, 3'd2);
        end

        // Reset mid-lockout, then a normal press.
        step(NK, 1, 0); expect_out("rl enter", CK, 1'b1, 3'd3);
        for (int i = 1; i <= 9; i++) step(NK, 0, 0);
        expect_out("rl cycle9", NK, 1'b1, 3'd3);
        rst = 1'b1;
        step(NK, 0, 0); expect_out("rl reset", NK, 1'b0, 3'd0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) step(4'h4, 0, 0);
        expect_out("rl pre", NK, 1'b0, 3'd0);
        step(4'h4, 0, 0); expect_out("rl press", 4'h4, 1'b0, 3'd0);
        step(NK, 0, 0); expect_out("rl after", NK, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
